// File: rtl/bfm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bfm_pkg
// Purpose  : Shared data width, operand type and wrap-around add helper for
//            the bfm_adder slice.
// Revision : 1.0 - initial release
// ============================================================================
package bfm_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] operand_t;

    // Modular add: the carry out of the top bit is dropped.
    function automatic operand_t add_wrap(operand_t a, operand_t b);
        return a + b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfm_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : bfm_delay_line
// Purpose  : WIDTH-wide, DEPTH-deep shift register with asynchronous
//            active-low clear. DEPTH=0 collapses to a plain wire.
// Revision : 1.0 - initial release
// ============================================================================
module bfm_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset have no load here; fold them into a sink.
            logic w_unused;
            assign w_unused = &{1'b0, clk_i, reset_i};
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift one stage per clock; reset clears every stage at once.
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bfm_adder.sv
`default_nettype none
// ============================================================================
// Module   : bfm_adder
// Purpose  : Streaming registered modular adder. Operands are captured every
//            clock, summed into a result register, then delayed by LATENCY-1
//            extra stages so res_o updates LATENCY edges after capture.
//            Legal LATENCY range is 1..8.
// Revision : 1.0 - initial release
// ============================================================================
module bfm_adder
    import bfm_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] A_s,
    input  logic [WIDTH-1:0] B_s,
    output logic [WIDTH-1:0] res_o
);

    localparam int C_EXTRA = LATENCY - 1;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum;

    // Operand capture stage.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= A_s;
            r_b <= B_s;
        end
    end

    generate
        if (WIDTH == DATA_W) begin : g_pkg_add
            assign w_sum = add_wrap(r_a, r_b);
        end else begin : g_generic_add
            assign w_sum = r_a + r_b;
        end
    endgenerate

    // Result register: the first (and for LATENCY=1 the only) output stage.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    bfm_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (C_EXTRA)
    ) u_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d       (r_sum),
        .q       (res_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_bfm_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfm_adder
// Purpose  : Self-checking bench for bfm_adder. Two instances (LATENCY=1 and
//            LATENCY=3) share one stimulus stream; a history of applied sums
//            predicts each output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfm_adder;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] A_s;
    logic [7:0] B_s;
    logic [7:0] res1;
    logic [7:0] res3;

    int checks   = 0;
    int failures = 0;

    // Reference model: sum applied at each edge, plus the first edge index
    // whose sample survives the most recent reset.
    logic [7:0] hist [0:4095];
    int cyc = 0;
    int rel = 0;

    always #5 clk_i = ~clk_i;

    bfm_adder #(.WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res1)
    );

    bfm_adder #(.WIDTH(8), .LATENCY(3)) u_dut3 (
        .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .res_o(res3)
    );

    function automatic logic [7:0] exp_res(int lat);
        int e;
        e = cyc - 1 - lat;
        if (e >= rel) return hist[e];
        return 8'h00;
    endfunction

    // Apply one pair for one clock and advance to 1 time unit after the edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        int s;
        A_s = a;
        B_s = b;
        s = int'(a) + int'(b);
        hist[cyc] = s[7:0];
        if (!reset_i) rel = cyc + 1;
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'h12, 8'h34);
            checks++;
            if (res1 !== 8'h00 || res3 !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: res1=%h res3=%h required 00", i, res1, res3);
            end
        end
        reset_i = 1'b1;
    endtask

    task automatic test_basic_add();
        drive(8'h03, 8'h04);
        drive(8'h00, 8'h00);
        checks++;
        if (res1 !== 8'h07) begin
            failures++;
            $display("FAIL basic_add: res1=%h required 07", res1);
        end
        drive(8'h00, 8'h00);
        drive(8'h00, 8'h00);
        checks++;
        if (res3 !== 8'h07) begin
            failures++;
            $display("FAIL basic_add_lat3: res3=%h required 07", res3);
        end
    endtask

    task automatic test_async_reset();
        drive(8'h03, 8'h04);
        drive(8'h03, 8'h04);
        checks++;
        if (res1 !== 8'h07) begin
            failures++;
            $display("FAIL async_pre: res1=%h required 07", res1);
        end
        #2;
        reset_i = 1'b0;
        rel = cyc;
        #1;
        checks++;
        if (res1 !== 8'h00 || res3 !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: res1=%h res3=%h required 00 before edge", res1, res3);
        end
        @(posedge clk_i);
        cyc++;
        #1;
        reset_i = 1'b1;
        drive(8'h00, 8'h00);
        checks++;
        if (res1 !== 8'h00 || res3 !== 8'h00) begin
            failures++;
            $display("FAIL async_no_replay: res1=%h res3=%h required 00", res1, res3);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] vec [3];
        logic [23:0] v;
        vec[0] = 24'hFF_01_00;
        vec[1] = 24'h80_80_00;
        vec[2] = 24'hF0_20_10;
        for (int i = 0; i < 3; i++) begin
            v = vec[i];
            drive(v[23:16], v[15:8]);
            drive(8'h00, 8'h00);
            checks++;
            if (res1 !== v[7:0]) begin
                failures++;
                $display("FAIL wrap %h+%h: res1=%h required %h", v[23:16], v[15:8], res1, v[7:0]);
            end
        end
    endtask

    task automatic test_streaming();
        logic [7:0] a;
        logic [7:0] b;
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                #2;
                reset_i = 1'b0;
                rel = cyc;
                #1;
                checks++;
                if (res1 !== 8'h00 || res3 !== 8'h00) begin
                    failures++;
                    $display("FAIL stream_reset_immediate: res1=%h res3=%h required 00", res1, res3);
                end
                #1;
            end
            if (i == 52) reset_i = 1'b1;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            drive(a, b);
            checks++;
            if (res1 !== exp_res(1) || res3 !== exp_res(3)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL stream pair %0d: res1=%h required %h res3=%h required %h",
                             i, res1, exp_res(1), res3, exp_res(3));
            end
        end
    endtask

    task automatic test_hold_constant();
        for (int i = 0; i < 6; i++) begin
            drive(8'h5A, 8'h33);
            if (i >= 3) begin
                checks++;
                if (res1 !== 8'h8D || res3 !== 8'h8D) begin
                    failures++;
                    $display("FAIL hold_constant cycle %0d: res1=%h res3=%h required 8d", i, res1, res3);
                end
            end
        end
    endtask

    task automatic test_latency3_pulse();
        logic [7:0] want;
        drive(8'h00, 8'h00);
        drive(8'h00, 8'h00);
        drive(8'h00, 8'h00);
        drive(8'h10, 8'h22);
        for (int k = 1; k <= 5; k++) begin
            drive(8'h00, 8'h00);
            want = (k == 3) ? 8'h32 : 8'h00;
            checks++;
            if (res3 !== want) begin
                failures++;
                $display("FAIL lat3_pulse edge +%0d: res3=%h required %h", k, res3, want);
            end
        end
    endtask

    initial begin
        A_s     = 8'h00;
        B_s     = 8'h00;
        reset_i = 1'b0;
        #1;
        test_reset();
        test_basic_add();
        test_async_reset();
        test_wrap();
        test_streaming();
        test_hold_constant();
        test_latency3_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
